// File: rtl/data_mem_io.sv
// data_mem_io: data-side responder for the 16/8-bit MIPS core.
// Byte RAM, memory-mapped GPIO and a prescaled compare timer with a
// level interrupt. Reads are combinational; all state updates on clk.
//
// Register map (above the RAM window):
//   0xF0 GPIO_OUT  R/W
//   0xF1 GPIO_IN   RO, two-flop synchronised pin value
//   0xF2 CNT       R, any write clears it
//   0xF3 CMP       R/W
//   0xF4 STATUS    bit0 match, write 1 to clear
//   0xF5 CTRL      bit0 en, bit1 autoreload
module data_mem_io #(
   parameter int RAM_WORDS = 240,
   parameter int PRESCALE  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [7:0]  addr,
   input  logic [7:0]  writedata,
   output logic [15:0] readdata,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic        timer_irq
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX  = PS_W'(PRESCALE - 1);
   localparam logic [8:0]      RAM_TOP = 9'(RAM_WORDS);

   localparam logic [7:0] A_GPIO_OUT = 8'hF0;
   localparam logic [7:0] A_GPIO_IN  = 8'hF1;
   localparam logic [7:0] A_CNT      = 8'hF2;
   localparam logic [7:0] A_CMP      = 8'hF3;
   localparam logic [7:0] A_STATUS   = 8'hF4;
   localparam logic [7:0] A_CTRL     = 8'hF5;

   logic [7:0]      mem [RAM_WORDS];

   logic [7:0]      gpio_out_q, gpio_out_d;
   logic [7:0]      sync1_q, sync1_d;
   logic [7:0]      sync2_q, sync2_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      cmp_q, cmp_d;
   logic            match_q, match_d;
   logic            en_q, en_d;
   logic            arl_q, arl_d;
   logic [PS_W-1:0] presc_q, presc_d;

   logic            sel_ram;
   logic            tick;
   logic            hit;
   logic [7:0]      rd8;

   assign sel_ram = ({1'b0, addr} < RAM_TOP);
   assign tick    = en_q && (presc_q == PS_MAX);
   assign hit     = (cnt_q == cmp_q);

   // Next-state: prescaler and timer first, then core writes override CNT/CTRL.
   always_comb begin
      gpio_out_d = gpio_out_q;
      sync1_d    = gpio_in;
      sync2_d    = sync1_q;
      cnt_d      = cnt_q;
      cmp_d      = cmp_q;
      match_d    = match_q;
      en_d       = en_q;
      arl_d      = arl_q;

      if (!en_q)
         presc_d = '0;
      else if (presc_q == PS_MAX)
         presc_d = '0;
      else
         presc_d = presc_q + 1'b1;

      // Clear first so a match arriving in the same cycle still sets the flag.
      if (memwrite && addr == A_STATUS && writedata[0])
         match_d = 1'b0;

      if (tick) begin
         if (!hit) begin
            cnt_d = cnt_q + 8'd1;
         end else begin
            match_d = 1'b1;
            if (arl_q)
               cnt_d = 8'h00;
            else
               en_d = 1'b0;
         end
      end

      if (memwrite) begin
         case (addr)
            A_GPIO_OUT: gpio_out_d = writedata;
            A_CNT:      cnt_d      = 8'h00;
            A_CMP:      cmp_d      = writedata;
            A_CTRL: begin
               en_d  = writedata[0];
               arl_d = writedata[1];
            end
            default: ;
         endcase
      end
   end

   // Peripheral state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_out_q <= 8'h00;
         sync1_q    <= 8'h00;
         sync2_q    <= 8'h00;
         cnt_q      <= 8'h00;
         cmp_q      <= 8'h00;
         match_q    <= 1'b0;
         en_q       <= 1'b0;
         arl_q      <= 1'b0;
         presc_q    <= '0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         cnt_q      <= cnt_d;
         cmp_q      <= cmp_d;
         match_q    <= match_d;
         en_q       <= en_d;
         arl_q      <= arl_d;
         presc_q    <= presc_d;
      end
   end

   // RAM write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (memwrite && sel_ram)
         mem[addr] <= writedata;
   end

   // Combinational read mux; returns pre-edge values during a write.
   always_comb begin
      rd8 = 8'h00;
      if (sel_ram) begin
         rd8 = mem[addr];
      end else begin
         case (addr)
            A_GPIO_OUT: rd8 = gpio_out_q;
            A_GPIO_IN:  rd8 = sync2_q;
            A_CNT:      rd8 = cnt_q;
            A_CMP:      rd8 = cmp_q;
            A_STATUS:   rd8 = {7'b0, match_q};
            A_CTRL:     rd8 = {6'b0, arl_q, en_q};
            default:    rd8 = 8'h00;
         endcase
      end
   end

   assign readdata  = {8'h00, rd8};
   assign gpio_out  = gpio_out_q;
   assign timer_irq = match_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: register/RAM vector table plus timer,
// GPIO synchroniser and reset sequences with hand-computed expectations.
module tb_data_mem_io;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [7:0]  addr;
   logic [7:0]  writedata;
   logic [15:0] readdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   int n_chk;
   int n_err;

   data_mem_io #(.RAM_WORDS(240), .PRESCALE(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .addr      (addr),
      .writedata (writedata),
      .readdata  (readdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic [7:0]  a;
      logic [7:0]  wd;
      logic        chk_rd;
      logic [15:0] exp_rd;
      logic [7:0]  exp_gpio;
      string       nm;
   } vec_t;

   vec_t vec[16];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      memwrite  = 1'b1;
      addr      = a;
      writedata = d;
      @(posedge clk);
      #1;
      memwrite  = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] a, input logic [15:0] exp);
      memwrite = 1'b0;
      addr     = a;
      #1;
      chk(nm, readdata, exp);
   endtask

   int seq_cnt[6];
   int seq_irq[6];

   initial begin
      n_chk     = 0;
      n_err     = 0;
      reset     = 1'b0;
      memwrite  = 1'b0;
      addr      = 8'h00;
      writedata = 8'h00;
      gpio_in   = 8'h00;

      vec[0]  = '{1'b1, 8'h10, 8'h5A, 1'b0, 16'h0000, 8'h00, "ram_w10"};
      vec[1]  = '{1'b1, 8'hEF, 8'hA5, 1'b0, 16'h0000, 8'h00, "ram_wEF"};
      vec[2]  = '{1'b0, 8'h10, 8'h00, 1'b1, 16'h005A, 8'h00, "ram_r10"};
      vec[3]  = '{1'b0, 8'hEF, 8'h00, 1'b1, 16'h00A5, 8'h00, "ram_rEF"};
      vec[4]  = '{1'b0, 8'hF8, 8'h00, 1'b1, 16'h0000, 8'h00, "unmap_rF8"};
      vec[5]  = '{1'b1, 8'hF8, 8'h77, 1'b1, 16'h0000, 8'h00, "unmap_wF8"};
      vec[6]  = '{1'b0, 8'hF8, 8'h00, 1'b1, 16'h0000, 8'h00, "unmap_rF8_after"};
      vec[7]  = '{1'b1, 8'h10, 8'h11, 1'b1, 16'h005A, 8'h00, "ram_old_on_write"};
      vec[8]  = '{1'b0, 8'h10, 8'h00, 1'b1, 16'h0011, 8'h00, "ram_new"};
      vec[9]  = '{1'b1, 8'hF0, 8'h3C, 1'b1, 16'h0000, 8'h3C, "gpio_out_w"};
      vec[10] = '{1'b0, 8'hF0, 8'h00, 1'b1, 16'h003C, 8'h3C, "gpio_out_r"};
      vec[11] = '{1'b1, 8'hF3, 8'h42, 1'b1, 16'h0000, 8'h3C, "cmp_old_on_write"};
      vec[12] = '{1'b0, 8'hF3, 8'h00, 1'b1, 16'h0042, 8'h3C, "cmp_r"};
      vec[13] = '{1'b1, 8'hF4, 8'hFE, 1'b1, 16'h0000, 8'h3C, "status_w0"};
      vec[14] = '{1'b1, 8'hF5, 8'hFC, 1'b1, 16'h0000, 8'h3C, "ctrl_upper_bits"};
      vec[15] = '{1'b0, 8'hF5, 8'h00, 1'b1, 16'h0000, 8'h3C, "ctrl_r"};

      // reset state
      #12;
      chk("rst_gpio_out", {8'h00, gpio_out}, 16'h0000);
      chk("rst_irq", {15'h0, timer_irq}, 16'h0000);
      rd_chk("rst_F0", 8'hF0, 16'h0000);
      rd_chk("rst_F2", 8'hF2, 16'h0000);
      rd_chk("rst_F3", 8'hF3, 16'h0000);
      rd_chk("rst_F4", 8'hF4, 16'h0000);
      rd_chk("rst_F5", 8'hF5, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      step(1);

      // vector table
      for (int i = 0; i < 16; i++) begin
         memwrite  = vec[i].we;
         addr      = vec[i].a;
         writedata = vec[i].wd;
         #1;
         if (vec[i].chk_rd)
            chk(vec[i].nm, readdata, vec[i].exp_rd);
         @(posedge clk);
         #1;
         memwrite = 1'b0;
         chk({vec[i].nm, "_gpio"}, {8'h00, gpio_out}, {8'h00, vec[i].exp_gpio});
      end

      // GPIO_IN two-flop latency
      gpio_in = 8'h81;
      rd_chk("gpio_in_lag0", 8'hF1, 16'h0000);
      step(1);
      rd_chk("gpio_in_lag1", 8'hF1, 16'h0000);
      step(1);
      rd_chk("gpio_in_lag2", 8'hF1, 16'h0081);

      // one-shot: CMP=3, en
      wr(8'hF3, 8'h03);
      wr(8'hF5, 8'h01);
      for (int k = 1; k <= 3; k++) begin
         step(4);
         rd_chk($sformatf("oneshot_cnt%0d", k), 8'hF2, 16'(k));
      end
      step(3);
      chk("oneshot_irq_early", {15'h0, timer_irq}, 16'h0000);
      step(1);
      chk("oneshot_irq", {15'h0, timer_irq}, 16'h0001);
      rd_chk("oneshot_status", 8'hF4, 16'h0001);
      rd_chk("oneshot_ctrl", 8'hF5, 16'h0000);
      rd_chk("oneshot_cnt_hold", 8'hF2, 16'h0003);
      step(8);
      rd_chk("oneshot_cnt_hold2", 8'hF2, 16'h0003);

      // autoreload: CMP=2, en+arl
      wr(8'hF4, 8'h01);
      wr(8'hF2, 8'h00);
      wr(8'hF3, 8'h02);
      wr(8'hF5, 8'h03);
      seq_cnt = '{1, 2, 0, 1, 2, 0};
      seq_irq = '{0, 0, 1, 1, 1, 1};
      for (int k = 0; k < 6; k++) begin
         step(4);
         rd_chk($sformatf("arl_cnt%0d", k), 8'hF2, 16'(seq_cnt[k]));
         chk($sformatf("arl_irq%0d", k), {15'h0, timer_irq}, 16'(seq_irq[k]));
      end
      wr(8'hF4, 8'h01);
      chk("arl_w1c", {15'h0, timer_irq}, 16'h0000);
      step(10);
      wr(8'hF4, 8'h01);
      chk("arl_set_beats_clear", {15'h0, timer_irq}, 16'h0001);
      rd_chk("arl_set_cnt", 8'hF2, 16'h0000);
      wr(8'hF4, 8'h01);
      chk("arl_clear_after", {15'h0, timer_irq}, 16'h0000);
      wr(8'hF5, 8'h00);

      // core CNT write in a tick cycle beats the increment
      wr(8'hF3, 8'h50);
      wr(8'hF2, 8'h00);
      wr(8'hF5, 8'h01);
      step(3);
      wr(8'hF2, 8'h10);
      rd_chk("prio_cnt_write", 8'hF2, 16'h0000);
      step(4);
      rd_chk("prio_next_tick", 8'hF2, 16'h0001);
      wr(8'hF5, 8'h00);

      // count to 0xFF, then wrap with CMP=0
      wr(8'hF2, 8'h00);
      wr(8'hF3, 8'hFF);
      wr(8'hF4, 8'h01);
      wr(8'hF5, 8'h01);
      for (int i = 0; i < 1200 && !timer_irq; i++)
         step(1);
      chk("wrap_wait_match", {15'h0, timer_irq}, 16'h0001);
      rd_chk("wrap_cnt_ff", 8'hF2, 16'h00FF);
      rd_chk("wrap_ctrl_off", 8'hF5, 16'h0000);
      wr(8'hF3, 8'h00);
      wr(8'hF4, 8'h01);
      wr(8'hF5, 8'h01);
      step(4);
      rd_chk("wrap_cnt0", 8'hF2, 16'h0000);
      chk("wrap_irq0", {15'h0, timer_irq}, 16'h0000);
      step(4);
      chk("wrap_match", {15'h0, timer_irq}, 16'h0001);
      rd_chk("wrap_match_cnt", 8'hF2, 16'h0000);
      rd_chk("wrap_match_ctrl", 8'hF5, 16'h0000);

      // async reset mid-count
      wr(8'hF4, 8'h01);
      wr(8'hF2, 8'h00);
      wr(8'hF3, 8'h01);
      wr(8'hF0, 8'hA5);
      wr(8'hF5, 8'h03);
      step(10);
      chk("pre_rst_irq", {15'h0, timer_irq}, 16'h0001);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_gpio_out", {8'h00, gpio_out}, 16'h0000);
      chk("arst_irq", {15'h0, timer_irq}, 16'h0000);
      rd_chk("arst_F0", 8'hF0, 16'h0000);
      rd_chk("arst_F1", 8'hF1, 16'h0000);
      rd_chk("arst_F2", 8'hF2, 16'h0000);
      rd_chk("arst_F3", 8'hF3, 16'h0000);
      rd_chk("arst_F5", 8'hF5, 16'h0000);
      step(2);
      @(negedge clk);
      reset = 1'b1;
      step(20);
      rd_chk("post_rst_cnt", 8'hF2, 16'h0000);
      rd_chk("post_rst_ctrl", 8'hF5, 16'h0000);
      chk("post_rst_irq", {15'h0, timer_irq}, 16'h0000);
      rd_chk("post_rst_gpio_in", 8'hF1, 16'h0081);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
